mem_burst_slave_ctrl: RTL and testbench
=======================================

Name: mem_burst_slave_ctrl

Overview:
Parametrised memory-side slave controller for the multiplexed address/data main bus. It decodes a contiguous range of pages and runs fixed-length read/write bursts against a synchronous memory array. It supports a configurable memory read latency and linear or wrapping bursts, and flags protocol violations. It sits between the main bus and one memory array, replacing single-page slaves so one instance can serve several pages.

Parameters:
BUSWIDTH, 16, width of multiplexed AddrData bus; also the data word width
PAGEBITS, 4, upper address bits holding the page number
PAGE_LO, MEMPAGE1 (mcDefs), lowest page decoded
PAGE_HI, MEMPAGE1 (mcDefs), highest page decoded; must be >= PAGE_LO
BURST, DATAPAYLOADSIZE (mcDefs), beats per transaction; power of two, >= 1
RD_LAT, 1, memory read latency in cycles from memRdEn to valid memDataOut; legal range 0..3
WRAP, 0, 0 = linear increment (offset wraps modulo page size); 1 = wrap within BURST-aligned block
Derived: OFFW = BUSWIDTH-PAGEBITS; NPG = PAGE_HI-PAGE_LO+1; MEM_AW = OFFW+$clog2(NPG)

Ports:
clk  in  1  bus clock
resetH  in  1  asynchronous, active-high reset
AddrValid  in  1  address phase strobe
rw  in  1  1 = read, 0 = write; sampled with AddrValid
AddrDataIn  in  BUSWIDTH  bus value: address in address phase, write data in write beats
AddrDataOut  out  BUSWIDTH  read data driven to the bus
AddrDataOE  out  1  bus output enable; high only on read data beats
memAddr  out  MEM_AW  array word address = {page-PAGE_LO, offset}
memRdEn  out  1  array read strobe
memWrEn  out  1  array write strobe
memDataIn  out  BUSWIDTH  array write data
memDataOut  in  BUSWIDTH  array read data
busy  out  1  transaction in progress (issue or drain)
protErr  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset: asynchronous; all outputs 0 immediately, state IDLE, counters cleared, read-valid pipeline flushed. No z is driven; the bus-level tristate is built outside from AddrDataOE.
- States: IDLE, WRITE, RD_ISSUE, RD_DRAIN.
- IDLE: a hit is AddrValid=1 and PAGE_LO <= AddrDataIn[BUSWIDTH-1 -: PAGEBITS] <= PAGE_HI. A hit at cycle T latches page and offset, loads the beat counter with BURST, then goes to WRITE (rw=0) or RD_ISSUE (rw=1) at T+1. A miss stays in IDLE with no outputs.
- WRITE: for beats k=0..BURST-1 at cycle T+1+k:
  - memWrEn=1, memAddr=addr_k, memDataIn=AddrDataIn (combinational pass-through).
  - Exits to IDLE after the last beat; busy falls at T+1+BURST.
- RD_ISSUE: for beats k=0..BURST-1 at cycle T+1+k, memRdEn=1 and memAddr=addr_k. After the last issue:
  - RD_LAT=0: go to IDLE.
  - RD_LAT>0: go to RD_DRAIN.
- Read data: beat k is on the bus at T+1+k+RD_LAT, with AddrDataOE=1 and AddrDataOut=memDataOut. It is tracked by an RD_LAT-deep valid shift register. AddrDataOut=0 whenever OE=0.
- RD_DRAIN: no memRdEn; stays RD_LAT cycles until the pipeline is empty, then goes to IDLE.
- busy=1 in every state other than IDLE.
- Address increment:
  - addr_0 = latched offset.
  - WRAP=0: offset+1 modulo 2^OFFW; the page field is unchanged.
  - WRAP=1: only the low log2(BURST) bits increment; the upper bits are held.
- memAddr=0 in any cycle with neither strobe high.
- Write and read strobes are never high in the same cycle.
- AddrValid while busy: ignored for decode, protErr=1 for that cycle, and the burst continues unaffected.
- A back-to-back request is accepted on the first IDLE cycle, which is the cycle busy is low.
- The beat counter is $clog2(BURST)+1 bits, so BURST is representable.

Decomposition:
- mcDefs: add typedef burst_state_t {IDLE, WRITE, RD_ISSUE, RD_DRAIN} and a page-in-range helper function. It already holds DATAPAYLOADSIZE and MEMPAGE* for reuse.
- One sub-module, rd_valid_pipe: parametrised RD_LAT shift register with async reset. It takes the issue strobe and produces the bus beat valid (AddrDataOE); RD_LAT=0 degenerates to a wire.

Test Plan:
- Write hit (PAGE_LO=PAGE_HI=2, BURST=4): AddrValid with 0x2010 at T, rw=0, data A0..A3 at T+1..T+4 -> memWrEn at T+1..T+4, memAddr 0x010..0x013, memDataIn A0..A3; busy low at T+5.
- Linear read across page end (RD_LAT=2): read 0x2FFE -> memRdEn at T+1..T+4 with memAddr FFE, FFF, 000, 001; AddrDataOE at T+3..T+6 carrying the array contents.
- Wrap read (WRAP=1, RD_LAT=0): read 0x200E -> memAddr 00E, 00F, 00C, 00D; OE at T+1..T+4.
- Multi-page/miss (PAGE_LO=2, PAGE_HI=3): 0x3004 -> memAddr 0x1004; 0x4004 and 0x1004 -> no strobes, busy stays 0.
- Protocol error: AddrValid during write beat 2 -> protErr=1 for exactly that cycle; all 4 writes complete at the original addresses.
- Reset mid-read: assert resetH at beat 1 -> memRdEn, OE and busy are 0 the same cycle; a new read after release returns the correct 4 beats.

Source files
------------

// File: rtl/mem_burst_slave_ctrl_pkg.sv
// Shared main-bus memory definitions (page map, payload size) plus burst-slave FSM
// states and the page-decode helper.
package mem_burst_slave_ctrl_pkg;

    localparam int unsigned DATAPAYLOADSIZE = 4;
    localparam int unsigned MEMPAGE1        = 2;
    localparam int unsigned MEMPAGE2        = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DRAIN = 2'd3
    } burst_state_t;

    // True when page lies in the inclusive decoded range [lo, hi]
    function automatic logic page_in_range(input int unsigned page,
                                           input int unsigned lo,
                                           input int unsigned hi);
        return (page >= lo) && (page <= hi);
    endfunction

endpackage

// File: rtl/mem_burst_slave_ctrl_if.sv
// Multiplexed address/data main-bus signals seen by a memory-side slave.
interface mem_burst_slave_ctrl_if #(
    parameter int unsigned BUSWIDTH = 16
) ();
    logic                AddrValid;
    logic                rw;
    logic [BUSWIDTH-1:0] AddrDataIn;
    logic [BUSWIDTH-1:0] AddrDataOut;
    logic                AddrDataOE;

    modport master (
        output AddrValid, rw, AddrDataIn,
        input  AddrDataOut, AddrDataOE
    );

    modport slave (
        input  AddrValid, rw, AddrDataIn,
        output AddrDataOut, AddrDataOE
    );
endinterface

// File: rtl/mem_burst_slave_ctrl_rd_valid_pipe.sv
// Read-beat valid tracker: delays the array read strobe by the memory read latency
// so it lines up with valid array data on the bus.
module rd_valid_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic valid
);
    generate
        if (RD_LAT == 0) begin : g_wire
            assign valid = issue;
        end else begin : g_pipe
            logic [RD_LAT-1:0] sr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) sr <= '0;
                else     sr <= RD_LAT'({sr, issue});
            end

            assign valid = sr[RD_LAT-1];
        end
    endgenerate
endmodule

// File: rtl/mem_burst_slave_ctrl.sv
// Memory-side burst slave: decodes a page range on the main bus and runs fixed-length
// linear or wrapping read/write bursts against a synchronous memory array.
module mem_burst_slave_ctrl
    import mem_burst_slave_ctrl_pkg::*;
#(
    parameter  int unsigned BUSWIDTH = 16,
    parameter  int unsigned PAGEBITS = 4,
    parameter  int unsigned PAGE_LO  = MEMPAGE1,
    parameter  int unsigned PAGE_HI  = MEMPAGE1,
    parameter  int unsigned BURST    = DATAPAYLOADSIZE,
    parameter  int unsigned RD_LAT   = 1,
    parameter  int unsigned WRAP     = 0,
    localparam int unsigned OFFW     = BUSWIDTH - PAGEBITS,
    localparam int unsigned NPG      = PAGE_HI - PAGE_LO + 1,
    localparam int unsigned MEM_AW   = OFFW + $clog2(NPG)
) (
    input  logic                 clk,
    input  logic                 resetH,
    mem_burst_slave_ctrl_if.slave bus,
    output logic [MEM_AW-1:0]    memAddr,
    output logic                 memRdEn,
    output logic                 memWrEn,
    output logic [BUSWIDTH-1:0]  memDataIn,
    input  logic [BUSWIDTH-1:0]  memDataOut,
    output logic                 busy,
    output logic                 protErr
);
    localparam int unsigned   CNTW  = $clog2(BURST) + 1;
    localparam logic [OFFW-1:0] WMASK = OFFW'(BURST - 1);

    burst_state_t        state, state_nx;
    logic [PAGEBITS-1:0] page_q;
    logic [OFFW-1:0]     off_q;
    logic [OFFW-1:0]     off_inc;
    logic [OFFW-1:0]     off_nx;
    logic [CNTW-1:0]     cnt_q;
    logic [1:0]          drain_q;
    logic                last_beat;
    logic                hit;
    logic                rd_oe;
    logic [PAGEBITS-1:0] page_in;

    assign page_in   = bus.AddrDataIn[BUSWIDTH-1 -: PAGEBITS];
    assign hit       = bus.AddrValid && page_in_range(32'(page_in), PAGE_LO, PAGE_HI);
    assign last_beat = (cnt_q == CNTW'(1));

    // Linear mode rolls over the whole page; wrap mode only advances the in-burst bits
    assign off_inc = off_q + OFFW'(1);
    assign off_nx  = (WRAP != 0) ? ((off_q & ~WMASK) | (off_inc & WMASK)) : off_inc;

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        memWrEn  = 1'b0;
        memRdEn  = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (hit) state_nx = bus.rw ? RD_ISSUE : WRITE;
            end
            WRITE: begin
                memWrEn = 1'b1;
                if (last_beat) state_nx = IDLE;
            end
            RD_ISSUE: begin
                memRdEn = 1'b1;
                if (last_beat) state_nx = (RD_LAT == 0) ? IDLE : RD_DRAIN;
            end
            RD_DRAIN: begin
                if (drain_q == 2'd1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            page_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        page_q <= page_in;
                        off_q  <= bus.AddrDataIn[OFFW-1:0];
                        cnt_q  <= CNTW'(BURST);
                    end
                end
                WRITE, RD_ISSUE: begin
                    off_q <= off_nx;
                    cnt_q <= cnt_q - CNTW'(1);
                    if (last_beat) drain_q <= 2'(RD_LAT);
                end
                RD_DRAIN: drain_q <= drain_q - 2'd1;
                default: ;
            endcase
        end
    end

    // Array address is the page index relative to PAGE_LO above the latched offset
    assign memAddr   = (memWrEn || memRdEn)
                     ? MEM_AW'({PAGEBITS'(32'(page_q) - PAGE_LO), off_q})
                     : '0;
    assign memDataIn = memWrEn ? bus.AddrDataIn : '0;
    assign protErr   = bus.AddrValid && (state != IDLE);

    rd_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_valid_pipe (
        .clk   (clk),
        .rst   (resetH),
        .issue (memRdEn),
        .valid (rd_oe)
    );

    assign bus.AddrDataOE  = rd_oe;
    assign bus.AddrDataOut = rd_oe ? memDataOut : '0;

endmodule

// File: tb/tb_mem_burst_slave_ctrl.sv
// Directed bench for mem_burst_slave_ctrl: three configurations sharing one clock/reset.
module tb_mem_burst_slave_ctrl;

    logic clk = 1'b0;
    logic resetH;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // A: page 2, RD_LAT=2, linear.  B: page 2, RD_LAT=0, wrap.  C: pages 2..3.
    mem_burst_slave_ctrl_if #(.BUSWIDTH(16)) bus_a ();
    mem_burst_slave_ctrl_if #(.BUSWIDTH(16)) bus_b ();
    mem_burst_slave_ctrl_if #(.BUSWIDTH(16)) bus_c ();

    logic [11:0] ma_a, ma_b;
    logic [12:0] ma_c;
    logic        rd_a, wr_a, busy_a, perr_a;
    logic        rd_b, wr_b, busy_b, perr_b;
    logic        rd_c, wr_c, busy_c, perr_c;
    logic [15:0] mdi_a, mdi_b, mdi_c;
    logic [15:0] mdo_a, mdo_b, mdo_c;
    logic [15:0] d1_a, d2_a;

    // Array models: contents are 0xC000|addr (A) and 0xB000|addr (B)
    always_ff @(posedge clk) begin
        d1_a <= 16'hC000 | 16'(ma_a);
        d2_a <= d1_a;
    end
    assign mdo_a = d2_a;
    assign mdo_b = 16'hB000 | 16'(ma_b);
    assign mdo_c = 16'h0000;

    mem_burst_slave_ctrl #(.PAGE_LO(2), .PAGE_HI(2), .BURST(4), .RD_LAT(2), .WRAP(0)) dut_a (
        .clk(clk), .resetH(resetH), .bus(bus_a), .memAddr(ma_a), .memRdEn(rd_a), .memWrEn(wr_a),
        .memDataIn(mdi_a), .memDataOut(mdo_a), .busy(busy_a), .protErr(perr_a));

    mem_burst_slave_ctrl #(.PAGE_LO(2), .PAGE_HI(2), .BURST(4), .RD_LAT(0), .WRAP(1)) dut_b (
        .clk(clk), .resetH(resetH), .bus(bus_b), .memAddr(ma_b), .memRdEn(rd_b), .memWrEn(wr_b),
        .memDataIn(mdi_b), .memDataOut(mdo_b), .busy(busy_b), .protErr(perr_b));

    mem_burst_slave_ctrl #(.PAGE_LO(2), .PAGE_HI(3), .BURST(4), .RD_LAT(1), .WRAP(0)) dut_c (
        .clk(clk), .resetH(resetH), .bus(bus_c), .memAddr(ma_c), .memRdEn(rd_c), .memWrEn(wr_c),
        .memDataIn(mdi_c), .memDataOut(mdo_c), .busy(busy_c), .protErr(perr_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [15:0] wdat  [4];
    logic [11:0] raddr [4];
    logic [15:0] rdat  [4];
    logic [15:0] pdat  [4];

    initial begin
        wdat[0] = 16'hA0A0; wdat[1] = 16'hA1A1; wdat[2] = 16'hA2A2; wdat[3] = 16'hA3A3;
        pdat[0] = 16'h1111; pdat[1] = 16'h2222; pdat[2] = 16'h2040; pdat[3] = 16'h4444;

        bus_a.AddrValid = 0; bus_a.rw = 0; bus_a.AddrDataIn = '0;
        bus_b.AddrValid = 0; bus_b.rw = 0; bus_b.AddrDataIn = '0;
        bus_c.AddrValid = 0; bus_c.rw = 0; bus_c.AddrDataIn = '0;
        resetH = 1'b1;
        repeat (2) @(posedge clk);
        smp();
        check("rst_busy", 32'(busy_a), 0);
        check("rst_wren", 32'(wr_a), 0);
        check("rst_rden", 32'(rd_a), 0);
        check("rst_oe",   32'(bus_a.AddrDataOE), 0);
        check("rst_addr", 32'(ma_a), 0);
        check("rst_dout", 32'(bus_a.AddrDataOut), 0);
        cyc();
        resetH = 1'b0;

        // Write hit at 0x2010
        bus_a.AddrValid = 1; bus_a.rw = 0; bus_a.AddrDataIn = 16'h2010;
        smp();
        check("wr_busy_T", 32'(busy_a), 0);
        cyc();
        bus_a.AddrValid = 0;
        for (int k = 0; k < 4; k++) begin
            bus_a.AddrDataIn = wdat[k];
            smp();
            check($sformatf("wr_en_%0d", k),   32'(wr_a), 1);
            check($sformatf("wr_rden_%0d", k), 32'(rd_a), 0);
            check($sformatf("wr_addr_%0d", k), 32'(ma_a), 32'h010 + 32'(k));
            check($sformatf("wr_data_%0d", k), 32'(mdi_a), 32'(wdat[k]));
            check($sformatf("wr_busy_%0d", k), 32'(busy_a), 1);
            cyc();
        end
        smp();
        check("wr_done_busy", 32'(busy_a), 0);
        check("wr_done_wren", 32'(wr_a), 0);
        check("wr_done_addr", 32'(ma_a), 0);

        // Linear read across the page end, RD_LAT=2
        raddr[0] = 12'hFFE; raddr[1] = 12'hFFF; raddr[2] = 12'h000; raddr[3] = 12'h001;
        rdat[0] = 16'hCFFE; rdat[1] = 16'hCFFF; rdat[2] = 16'hC000; rdat[3] = 16'hC001;
        bus_a.AddrValid = 1; bus_a.rw = 1; bus_a.AddrDataIn = 16'h2FFE;
        cyc();
        bus_a.AddrValid = 0; bus_a.AddrDataIn = '0;
        for (int c = 1; c <= 6; c++) begin
            smp();
            check($sformatf("rd_en_%0d", c), 32'(rd_a), (c <= 4) ? 1 : 0);
            check($sformatf("rd_addr_%0d", c), 32'(ma_a), (c <= 4) ? 32'(raddr[c-1]) : 0);
            check($sformatf("rd_oe_%0d", c), 32'(bus_a.AddrDataOE), (c >= 3) ? 1 : 0);
            check($sformatf("rd_dat_%0d", c), 32'(bus_a.AddrDataOut), (c >= 3) ? 32'(rdat[c-3]) : 0);
            check($sformatf("rd_busy_%0d", c), 32'(busy_a), 1);
            cyc();
        end
        smp();
        check("rd_done_busy", 32'(busy_a), 0);
        check("rd_done_oe",   32'(bus_a.AddrDataOE), 0);

        // Wrapping read, RD_LAT=0
        raddr[0] = 12'h00E; raddr[1] = 12'h00F; raddr[2] = 12'h00C; raddr[3] = 12'h00D;
        bus_b.AddrValid = 1; bus_b.rw = 1; bus_b.AddrDataIn = 16'h200E;
        cyc();
        bus_b.AddrValid = 0; bus_b.AddrDataIn = '0;
        for (int c = 1; c <= 4; c++) begin
            smp();
            check($sformatf("wrap_addr_%0d", c), 32'(ma_b), 32'(raddr[c-1]));
            check($sformatf("wrap_oe_%0d", c), 32'(bus_b.AddrDataOE), 1);
            check($sformatf("wrap_dat_%0d", c), 32'(bus_b.AddrDataOut), 32'h0000B000 | 32'(raddr[c-1]));
            cyc();
        end
        smp();
        check("wrap_done_busy", 32'(busy_b), 0);
        check("wrap_done_oe",   32'(bus_b.AddrDataOE), 0);

        // Multi-page decode and misses
        bus_c.AddrValid = 1; bus_c.rw = 0; bus_c.AddrDataIn = 16'h3004;
        cyc();
        bus_c.AddrValid = 0; bus_c.AddrDataIn = 16'h5555;
        smp();
        check("mp_wren",  32'(wr_c), 1);
        check("mp_addr0", 32'(ma_c), 32'h1004);
        cyc();
        smp();
        check("mp_addr1", 32'(ma_c), 32'h1005);
        repeat (3) cyc();
        smp();
        check("mp_done_busy", 32'(busy_c), 0);
        bus_c.AddrValid = 1; bus_c.AddrDataIn = 16'h4004;
        cyc();
        bus_c.AddrValid = 0;
        smp();
        check("miss_hi_busy", 32'(busy_c), 0);
        check("miss_hi_wren", 32'(wr_c), 0);
        bus_c.AddrValid = 1; bus_c.AddrDataIn = 16'h1004;
        cyc();
        bus_c.AddrValid = 0;
        smp();
        check("miss_lo_busy", 32'(busy_c), 0);
        check("miss_lo_wren", 32'(wr_c), 0);

        // AddrValid during write beat 2 flags an error without disturbing the burst
        bus_a.AddrValid = 1; bus_a.rw = 0; bus_a.AddrDataIn = 16'h2020;
        cyc();
        for (int k = 0; k < 4; k++) begin
            bus_a.AddrValid = (k == 2);
            bus_a.AddrDataIn = pdat[k];
            smp();
            check($sformatf("pe_err_%0d", k),  32'(perr_a), (k == 2) ? 1 : 0);
            check($sformatf("pe_addr_%0d", k), 32'(ma_a), 32'h020 + 32'(k));
            check($sformatf("pe_data_%0d", k), 32'(mdi_a), 32'(pdat[k]));
            check($sformatf("pe_wren_%0d", k), 32'(wr_a), 1);
            cyc();
        end
        bus_a.AddrValid = 0;
        smp();
        check("pe_done_busy", 32'(busy_a), 0);
        check("pe_done_err",  32'(perr_a), 0);

        // Reset asserted during read beat 1, then a clean read
        bus_a.AddrValid = 1; bus_a.rw = 1; bus_a.AddrDataIn = 16'h2100;
        cyc();
        bus_a.AddrValid = 0;
        smp();
        check("mr_rden_b0", 32'(rd_a), 1);
        cyc();
        resetH = 1'b1;
        smp();
        check("mr_rden", 32'(rd_a), 0);
        check("mr_oe",   32'(bus_a.AddrDataOE), 0);
        check("mr_busy", 32'(busy_a), 0);
        cyc();
        resetH = 1'b0;
        bus_a.AddrValid = 1; bus_a.rw = 1; bus_a.AddrDataIn = 16'h2200;
        cyc();
        bus_a.AddrValid = 0;
        for (int c = 1; c <= 6; c++) begin
            smp();
            check($sformatf("mr2_oe_%0d", c), 32'(bus_a.AddrDataOE), (c >= 3) ? 1 : 0);
            check($sformatf("mr2_dat_%0d", c), 32'(bus_a.AddrDataOut),
                  (c >= 3) ? 32'h0000C200 + 32'(c - 3) : 0);
            cyc();
        end
        smp();
        check("mr2_done_busy", 32'(busy_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
